// File: rtl/window_cache_fill_if.sv
// Pixel stream (valid/ready) and cache block-write bus of the window cache fill block.
// The slave modport belongs to window_cache_fill; the master modport belongs to the stream source / cache side.
interface window_cache_fill_if #(
    parameter int PIX_W  = 8,
    parameter int WORDS  = 4,
    parameter int BLOCKS = 16,
    parameter int ROWS   = 8
);
    logic                      pix_valid;
    logic                      pix_ready;
    logic [PIX_W-1:0]          pix_data;
    logic                      pix_sof;
    logic                      wc_we;
    logic [$clog2(ROWS)-1:0]   wc_waddr_y;
    logic [$clog2(BLOCKS)-1:0] wc_waddr_block;
    logic [WORDS*PIX_W-1:0]    wc_wdata;

    modport master (
        output pix_valid, pix_data, pix_sof,
        input  pix_ready, wc_we, wc_waddr_y, wc_waddr_block, wc_wdata
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof,
        output pix_ready, wc_we, wc_waddr_y, wc_waddr_block, wc_wdata
    );
endinterface

// File: rtl/window_cache_fill.sv
// Packs a raster pixel stream into WORDS-pixel blocks and writes them into a ROWS-deep circular
// row cache. Defining WINDOW_CACHE_FILL_ERR_EN adds the err_sticky output.
module window_cache_fill #(
    parameter int PIX_W  = 8,
    parameter int WORDS  = 4,
    parameter int BLOCKS = 16,
    parameter int ROWS   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    window_cache_fill_if.slave        bus,
    input  logic                      rd_release,
    output logic                      row_done,
    output logic [$clog2(ROWS+1)-1:0] rows_avail
`ifdef WINDOW_CACHE_FILL_ERR_EN
    ,
    output logic                      err_sticky
`endif
);
    localparam int EW = $clog2(WORDS);
    localparam int BW = $clog2(BLOCKS);
    localparam int YW = $clog2(ROWS);
    localparam int AW = $clog2(ROWS+1);
    localparam int DW = WORDS*PIX_W;

    typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

    state_t          state_reg, state_next;
    logic [EW-1:0]   elm_reg, elm_next;
    logic [BW-1:0]   blk_reg, blk_next;
    logic [YW-1:0]   row_reg, row_next;
    logic            row_pend_reg, row_pend_next;
    logic [AW-1:0]   avail_reg, avail_next;
    logic [DW-1:0]   pack_reg, pack_next;
    logic            ready_reg, ready_next;
    logic            we_reg, we_next;
    logic [YW-1:0]   waddr_y_reg, waddr_y_next;
    logic [BW-1:0]   waddr_blk_reg, waddr_blk_next;
    logic [DW-1:0]   wdata_reg, wdata_next;

    logic            accept;
    logic            restart;
    logic [EW-1:0]   elm_sel;
    logic [DW-1:0]   lane_data;

    assign accept  = bus.pix_valid && ready_reg;
    assign restart = accept && bus.pix_sof;
    assign elm_sel = restart ? '0 : elm_reg;

    // Packing register with the incoming pixel merged into its lane.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
            assign lane_data[gi*PIX_W +: PIX_W] =
                (elm_sel == EW'(gi)) ? bus.pix_data : pack_reg[gi*PIX_W +: PIX_W];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        elm_next       = elm_reg;
        blk_next       = blk_reg;
        row_next       = row_reg;
        row_pend_next  = 1'b0;
        avail_next     = avail_reg;
        pack_next      = pack_reg;
        we_next        = 1'b0;
        waddr_y_next   = waddr_y_reg;
        waddr_blk_next = waddr_blk_reg;
        wdata_next     = wdata_reg;

        // Non-SOF pixels in IDLE are consumed but discarded.
        if (accept && (state_reg != IDLE || bus.pix_sof)) begin
            pack_next = lane_data;
            if (restart) begin
                elm_next = EW'(1);
                blk_next = '0;
                row_next = '0;
            end else if (elm_reg == EW'(WORDS-1)) begin
                elm_next       = '0;
                we_next        = 1'b1;
                wdata_next     = lane_data;
                waddr_y_next   = row_reg;
                waddr_blk_next = blk_reg;
                if (blk_reg == BW'(BLOCKS-1)) begin
                    blk_next      = '0;
                    row_pend_next = 1'b1;
                end else begin
                    blk_next = blk_reg + 1'b1;
                end
            end else begin
                elm_next = elm_reg + 1'b1;
            end
        end

        // row_pend is the row_done cycle: the row is committed at its end.
        if (row_pend_reg) begin
            row_next = (row_reg == YW'(ROWS-1)) ? '0 : row_reg + 1'b1;
        end

        if (restart) begin
            avail_next = '0;
        end else if (row_pend_reg && !rd_release) begin
            avail_next = (avail_reg == AW'(ROWS)) ? avail_reg : avail_reg + 1'b1;
        end else if (!row_pend_reg && rd_release && avail_reg != '0) begin
            avail_next = avail_reg - 1'b1;
        end

        if (state_reg == IDLE) begin
            if (restart) begin
                state_next = FILL;
            end
        end else begin
            state_next = (avail_next == AW'(ROWS)) ? STALL : FILL;
        end

        ready_next = (state_next == IDLE) ||
                     (state_next == FILL && avail_next < AW'(ROWS) && !row_pend_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            elm_reg       <= '0;
            blk_reg       <= '0;
            row_reg       <= '0;
            row_pend_reg  <= 1'b0;
            avail_reg     <= '0;
            pack_reg      <= '0;
            ready_reg     <= 1'b0;
            we_reg        <= 1'b0;
            waddr_y_reg   <= '0;
            waddr_blk_reg <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            elm_reg       <= elm_next;
            blk_reg       <= blk_next;
            row_reg       <= row_next;
            row_pend_reg  <= row_pend_next;
            avail_reg     <= avail_next;
            pack_reg      <= pack_next;
            ready_reg     <= ready_next;
            we_reg        <= we_next;
            waddr_y_reg   <= waddr_y_next;
            waddr_blk_reg <= waddr_blk_next;
            wdata_reg     <= wdata_next;
        end
    end

    assign bus.pix_ready      = ready_reg;
    assign bus.wc_we          = we_reg;
    assign bus.wc_waddr_y     = waddr_y_reg;
    assign bus.wc_waddr_block = waddr_blk_reg;
    assign bus.wc_wdata       = wdata_reg;
    assign row_done           = row_pend_reg;
    assign rows_avail         = avail_reg;

`ifdef WINDOW_CACHE_FILL_ERR_EN
    logic err_reg, err_next;

    // Truncated row (SOF mid-row) or a release with nothing to release.
    always_comb begin
        err_next = err_reg ||
                   (restart && state_reg == FILL && (elm_reg != '0 || blk_reg != '0)) ||
                   (rd_release && avail_reg == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err_sticky = err_reg;
`endif
endmodule

// File: tb/tb_window_cache_fill.sv
// Directed bench for window_cache_fill: packing, row wrap, back-pressure, release rules,
// SOF restart and asynchronous reset. Prints one line per block write.
module tb_window_cache_fill;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_release;
    logic       row_done;
    logic [3:0] rows_avail;
`ifdef WINDOW_CACHE_FILL_ERR_EN
    logic       err_sticky;
`endif

    int checks = 0;
    int errors = 0;
    int last_wait;
    int first_wait;

    typedef struct {
        logic [2:0]  y;
        logic [3:0]  b;
        logic [31:0] d;
        logic        done;
    } wr_t;
    wr_t wr_q[$];

    window_cache_fill_if bus ();

    window_cache_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rd_release (rd_release),
        .row_done   (row_done),
        .rows_avail (rows_avail)
`ifdef WINDOW_CACHE_FILL_ERR_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wc_we === 1'b1) begin
            wr_t w;
            w.y    = bus.wc_waddr_y;
            w.b    = bus.wc_waddr_block;
            w.d    = bus.wc_wdata;
            w.done = row_done;
            wr_q.push_back(w);
            $display("WR y=%0d blk=%0d data=%08h row_done=%b avail=%0d",
                     w.y, w.b, w.d, w.done, rows_avail);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int r, input int p);
        return 8'(r*37 + (p+1)*17);
    endfunction

    function automatic logic [31:0] exp_block(input int r, input int b);
        logic [31:0] e;
        for (int k = 0; k < 4; k++) e[k*8 +: 8] = pv(r, b*4 + k);
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = '0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic sof);
        int w;
        w = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        while (bus.pix_ready !== 1'b1 && w < 50) begin
            tick(1);
            w++;
        end
        if (w >= 50) chk("accept_timeout", {63'd0, bus.pix_ready}, 64'd1);
        tick(1);
        last_wait = w;
    endtask

    task automatic stream(input int r, input int p0, input int p1, input logic sof_first);
        for (int p = p0; p <= p1; p++) begin
            send_pixel(pv(r, p), sof_first && (p == p0));
            if (p == p0) first_wait = last_wait;
        end
    endtask

    task automatic release_pulse();
        rd_release = 1'b1;
        tick(1);
        rd_release = 1'b0;
        tick(1);
    endtask

    task automatic check_row(input int idx, input int r, input int y);
        if (wr_q.size() < idx + 16) begin
            chk("wr_count", 64'(wr_q.size()), 64'(idx + 16));
        end else begin
            for (int b = 0; b < 16; b++) begin
                chk($sformatf("r%0d_b%0d_y", r, b), 64'(wr_q[idx+b].y), 64'(y));
                chk($sformatf("r%0d_b%0d_blk", r, b), 64'(wr_q[idx+b].b), 64'(b));
                chk($sformatf("r%0d_b%0d_data", r, b), 64'(wr_q[idx+b].d), 64'(exp_block(r, b)));
                chk($sformatf("r%0d_b%0d_done", r, b), 64'(wr_q[idx+b].done), 64'(b == 15));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 64'(bus.pix_ready), 64'd0);
        chk({tag, "_we"}, 64'(bus.wc_we), 64'd0);
        chk({tag, "_y"}, 64'(bus.wc_waddr_y), 64'd0);
        chk({tag, "_blk"}, 64'(bus.wc_waddr_block), 64'd0);
        chk({tag, "_wdata"}, 64'(bus.wc_wdata), 64'd0);
        chk({tag, "_row_done"}, 64'(row_done), 64'd0);
        chk({tag, "_avail"}, 64'(rows_avail), 64'd0);
`ifdef WINDOW_CACHE_FILL_ERR_EN
        chk({tag, "_err"}, 64'(err_sticky), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ready_hi;
        int waits;
        int n;

        rst_n      = 1'b0;
        rd_release = 1'b0;
        idle_bus();
        tick(3);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(1);
        chk("idle_ready", 64'(bus.pix_ready), 64'd1);

        // First block: SOF + 0x11..0x44, write visible one cycle after the 4th accept.
        stream(0, 0, 3, 1'b1);
        chk("blk0_we", 64'(bus.wc_we), 64'd1);
        chk("blk0_y", 64'(bus.wc_waddr_y), 64'd0);
        chk("blk0_blk", 64'(bus.wc_waddr_block), 64'd0);
        chk("blk0_data", 64'(bus.wc_wdata), 64'h4433_2211);

        // Rest of row 0, then row 1: one-cycle ready drop at the row boundary.
        stream(0, 4, 63, 1'b0);
        chk("row0_done_pulse", 64'(row_done), 64'd1);
        stream(1, 0, 0, 1'b0);
        chk("row_end_ready_low", 64'(first_wait), 64'd1);
        chk("avail_after_row0", 64'(rows_avail), 64'd1);
        stream(1, 1, 63, 1'b0);

        // Fill all eight rows without releases.
        for (int r = 2; r < 8; r++) stream(r, 0, 63, 1'b0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = pv(8, 0);
        ready_hi = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.pix_ready === 1'b1) ready_hi++;
        end
        chk("full_ready_cycles", 64'(ready_hi), 64'd0);
        chk("full_avail", 64'(rows_avail), 64'd8);
        rd_release = 1'b1;
        tick(1);
        rd_release = 1'b0;
        chk("release_avail", 64'(rows_avail), 64'd7);
        chk("release_ready", 64'(bus.pix_ready), 64'd1);
        stream(8, 0, 63, 1'b0);
        idle_bus();
        tick(2);
        chk("refull_avail", 64'(rows_avail), 64'd8);
        for (int r = 0; r < 8; r++) check_row(r*16, r, r);
        check_row(128, 8, 0);

        // Release coincident with row_done leaves the count unchanged.
        for (int i = 0; i < 5; i++) release_pulse();
        chk("avail_3", 64'(rows_avail), 64'd3);
        stream(9, 0, 63, 1'b0);
        chk("row9_done", 64'(row_done), 64'd1);
        idle_bus();
        rd_release = 1'b1;
        tick(1);
        rd_release = 1'b0;
        chk("coincident_avail", 64'(rows_avail), 64'd3);
        check_row(144, 9, 1);
        for (int i = 0; i < 3; i++) release_pulse();
        chk("avail_0", 64'(rows_avail), 64'd0);
`ifdef WINDOW_CACHE_FILL_ERR_EN
        chk("err_before_underflow", 64'(err_sticky), 64'd0);
`endif
        release_pulse();
        chk("underflow_avail", 64'(rows_avail), 64'd0);
`ifdef WINDOW_CACHE_FILL_ERR_EN
        chk("err_underflow", 64'(err_sticky), 64'd1);
`endif

        // Reset into IDLE: non-SOF pixels are swallowed without writes.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        wr_q.delete();
        tick(1);
        waits = 0;
        for (int i = 0; i < 10; i++) begin
            send_pixel(8'(i + 1), 1'b0);
            waits += last_wait;
        end
        idle_bus();
        tick(3);
        chk("idle_waits", 64'(waits), 64'd0);
        chk("idle_no_writes", 64'(wr_q.size()), 64'd0);

        // SOF mid-row drops the partial block and clears rows_avail.
        stream(10, 0, 63, 1'b1);
        stream(11, 0, 5, 1'b0);
        idle_bus();
        tick(2);
        chk("pre_sof_avail", 64'(rows_avail), 64'd1);
`ifdef WINDOW_CACHE_FILL_ERR_EN
        chk("err_pre_sof", 64'(err_sticky), 64'd0);
`endif
        stream(12, 0, 3, 1'b1);
        chk("sof_avail", 64'(rows_avail), 64'd0);
        idle_bus();
        tick(2);
`ifdef WINDOW_CACHE_FILL_ERR_EN
        chk("err_truncated", 64'(err_sticky), 64'd1);
`endif
        check_row(0, 10, 0);
        chk("sof_wr_count", 64'(wr_q.size()), 64'd18);
        if (wr_q.size() >= 18) begin
            chk("partial_y", 64'(wr_q[16].y), 64'd1);
            chk("partial_data", 64'(wr_q[16].d), 64'(exp_block(11, 0)));
            chk("restart_y", 64'(wr_q[17].y), 64'd0);
            chk("restart_blk", 64'(wr_q[17].b), 64'd0);
            chk("restart_data", 64'(wr_q[17].d), 64'(exp_block(12, 0)));
        end

        // Asynchronous reset with elm=2 of a block.
        stream(12, 4, 63, 1'b0);
        stream(13, 0, 1, 1'b0);
        idle_bus();
        chk("pre_rst_avail", 64'(rows_avail), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        n = wr_q.size();
        tick(3);
        chk("rst_no_writes", 64'(wr_q.size()), 64'(n));
        rst_n = 1'b1;
        wr_q.delete();
        tick(1);
        stream(14, 0, 3, 1'b1);
        idle_bus();
        tick(2);
        chk("post_rst_count", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() >= 1) begin
            chk("post_rst_y", 64'(wr_q[0].y), 64'd0);
            chk("post_rst_blk", 64'(wr_q[0].b), 64'd0);
            chk("post_rst_data", 64'(wr_q[0].d), 64'(exp_block(14, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_cache_fill.md
Name: window_cache_fill

Overview:
- Write-side producer for the window cache.
- Accepts a raster pixel stream with valid/ready handshake and packs WORDS consecutive pixels into one block.
- Issues block writes (row, block, data, write enable) into a circular buffer of ROWS cache rows.
- Tracks filled-but-unconsumed rows so the window reader can release them; back-pressures the stream when all rows are occupied.

Parameters:
PIX_W, 8, bits per pixel
WORDS, 4, pixels per block (power of 2, ≥2)
BLOCKS, 16, blocks per row (line width = WORDS*BLOCKS pixels)
ROWS, 8, cache rows in the circular buffer (≥2)

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
pix_valid  input  1  pixel present
pix_ready  output  1  block accepts pixel this cycle
pix_data  input  PIX_W  pixel value
pix_sof  input  1  qualifies pix_data as first pixel of a frame
rd_release  input  1  reader frees the oldest filled row (one-cycle pulse)
wc_we  output  1  block write strobe
wc_waddr_y  output  $clog2(ROWS)  cache row of write
wc_waddr_block  output  $clog2(BLOCKS)  block index within row
wc_wdata  output  WORDS*PIX_W  packed block, pixel k at bits [k*PIX_W +: PIX_W]
row_done  output  1  pulses with final block write of a row
rows_avail  output  $clog2(ROWS+1)  filled, unreleased rows

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - All outputs 0; pix_ready 0; state IDLE.
  - Counters elm, blk, row = 0; row_pend = 0; packing register = 0.
- Accept: a pixel is accepted when pix_valid && pix_ready.
- States:
  - IDLE: pix_ready=1. Accepted pixels with pix_sof=0 are discarded. An accepted pixel with pix_sof=1 -> FILL; it is stored as elm 0 of blk 0, row 0.
  - FILL: pix_ready = (rows_avail < ROWS) && !row_pend. Go to STALL when rows_avail reaches ROWS.
  - STALL: pix_ready=0. Return to FILL on the cycle after rd_release makes rows_avail < ROWS.
- SOF in FILL: an accepted pixel with pix_sof=1 restarts packing.
  - Partial block and partial row are dropped with no write issued.
  - elm, blk and row are reset to 0; rows_avail is cleared to 0 on the same edge.
  - The pixel becomes elm 0.
- Packing:
  - An accepted pixel is written into lane elm; elm increments.
  - On accepting lane WORDS-1, elm wraps to 0. On the next cycle: wc_we=1, wc_wdata = full block, wc_waddr_y = row, wc_waddr_block = blk (registered outputs, 1-cycle latency).
  - blk increments after the write and wraps to 0 after BLOCKS-1.
- Row end: accepting the last pixel of blk BLOCKS-1 sets row_pend, which forces pix_ready low for exactly one cycle. In that following cycle:
  - wc_we=1 and row_done=1;
  - row = (row+1) mod ROWS;
  - rows_avail increments;
  - row_pend clears.
- rows_avail update rules:
  - row_done && rd_release in the same cycle -> unchanged.
  - rd_release alone with rows_avail==0 -> ignored, stays 0.
  - Never exceeds ROWS.
- Outputs wc_waddr_y, wc_waddr_block and wc_wdata hold their last values when wc_we=0.
- Reset asserted mid-row: immediate return to reset values; no further writes.

Optional Feature:
- WINDOW_CACHE_FILL_ERR_EN adds output err_sticky (1 bit, reset 0).
- It is set, and held until reset, on either condition:
  - pix_sof accepted in FILL with elm!=0 or blk!=0 (truncated row);
  - rd_release while rows_avail==0.
- Without the macro the port and logic are absent and behaviour is otherwise identical.

Test Plan (defaults PIX_W=8, WORDS=4, BLOCKS=16, ROWS=8):
- Reset, then SOF + 4 pixels 0x11,0x22,0x33,0x44 back-to-back -> one cycle after 4th accept: wc_we=1, wc_waddr_y=0, wc_waddr_block=0, wc_wdata=0x44332211.
- Full row of 64 pixels, valid always high -> 16 writes, blocks 0..15; row_done with block 15; pix_ready low exactly 1 cycle; rows_avail=1; next block goes to wc_waddr_y=1, block 0.
- Stream 8 rows, no rd_release -> rows_avail=8, pix_ready stays 0; pulse rd_release -> rows_avail=7; pix_ready=1 after 1 cycle; 9th row writes wc_waddr_y=0 (wrap).
- rd_release coincident with row_done at rows_avail=3 -> rows_avail stays 3; rd_release at rows_avail=0 -> stays 0 (err_sticky=1 if macro defined).
- Pixels without SOF in IDLE -> accepted, wc_we never asserts; SOF after 6 pixels of a row in FILL -> no write for the partial block, rows_avail=0, next write at row 0 block 0.
- rst_n low mid-block (elm=2) -> outputs immediately 0; after release, SOF stream restarts at row 0 block 0 with correct data.
